// File: rtl/regfile_writeback_unit_if.sv
// Bundles the write-back unit's signals: the ALU result, the load issue and
// load response paths, the decode hazard query and the register-file write port.
//   master : upstream side (execute stage, cache controller, decode, RF)
//   slave  : the write-back unit itself
interface regfile_writeback_unit_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  // Execute-stage result, always accepted
  logic            alu_valid;
  logic [RW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;

  // Load issue, used for scoreboard tracking
  logic            ld_issue;
  logic [RW-1:0]   ld_rd;

  // Cache load response with ready/valid handshake
  logic            ld_rsp_valid;
  logic [RW-1:0]   ld_rsp_rd;
  logic [XLEN-1:0] ld_rsp_data;
  logic            ld_rsp_ready;

  // Decode-stage hazard query
  logic [RW-1:0]   raddr1;
  logic [RW-1:0]   raddr2;
  logic            stall;
  logic [NREG-1:0] pending;

  // Register-file write port
  logic            reg_wr;
  logic [RW-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_rd,
    output ld_rsp_valid, ld_rsp_rd, ld_rsp_data,
    input  ld_rsp_ready,
    output raddr1, raddr2,
    input  stall, pending,
    input  reg_wr, waddr, wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_rd,
    input  ld_rsp_valid, ld_rsp_rd, ld_rsp_data,
    output ld_rsp_ready,
    input  raddr1, raddr2,
    output stall, pending,
    output reg_wr, waddr, wdata
  );
endinterface

// File: rtl/regfile_writeback_unit.sv
// Register-file write-side front end.
// Merges execute-stage ALU results with out-of-order load returns onto the
// single register-file write port. ALU results have fixed priority; load
// returns wait in a circular FIFO. A pending-load scoreboard raises stall
// whenever a decode source register still waits on a load.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of regfile_writeback_unit_if (ALU result, load
//              issue, load response handshake, hazard query, RF write port)
// DEPTH must be a power of two and at least 2, so pointer wrap is the
// natural roll-over of a clog2(DEPTH)-bit counter.
module regfile_writeback_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  regfile_writeback_unit_if.slave bus
);

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  // One buffered load return
  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ld_entry_t;

  // Load-response FIFO storage and bookkeeping
  ld_entry_t       fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Scoreboard
  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] set_mask, clr_mask;

  // Registered write port
  logic            reg_wr_q, reg_wr_d;
  logic [RW-1:0]   waddr_q,  waddr_d;
  logic [XLEN-1:0] wdata_q,  wdata_d;

  // Per-cycle decisions
  logic            rsp_ready;
  logic            rsp_accept;
  logic            enq;
  logic            alu_wr;
  logic            fifo_empty;
  logic            pop;
  ld_entry_t       head;

  // Ready depends only on registered occupancy: no pop-through when full
  assign rsp_ready  = (count_q != CW'(DEPTH));
  assign rsp_accept = bus.ld_rsp_valid & rsp_ready;
  // Responses to x0 are handshaken but never stored
  assign enq        = rsp_accept & (bus.ld_rsp_rd != '0);

  assign alu_wr     = bus.alu_valid & (bus.alu_rd != '0);
  assign fifo_empty = (count_q == '0);
  // An ALU op to x0 is dropped and does not block the pop
  assign pop        = ~alu_wr & ~fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  // Next-state: write arbitration, FIFO pointers and scoreboard update
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    reg_wr_d  = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    set_mask  = '0;
    clr_mask  = '0;
    pending_d = pending_q;

    if (alu_wr) begin
      reg_wr_d = 1'b1;
      waddr_d  = bus.alu_rd;
      wdata_d  = bus.alu_data;
    end else if (pop) begin
      reg_wr_d         = 1'b1;
      waddr_d          = head.rd;
      wdata_d          = head.data;
      rd_ptr_d         = rd_ptr_q + PW'(1);
      clr_mask[head.rd] = 1'b1;
    end

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(enq) - CW'(pop);

    if (bus.ld_issue && (bus.ld_rd != '0)) begin
      set_mask[bus.ld_rd] = 1'b1;
    end

    // Set is applied after clear so a same-register collision stays pending
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // Control and output state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      reg_wr_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      reg_wr_q  <= reg_wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // FIFO payload needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_q[wr_ptr_q] <= '{rd: bus.ld_rsp_rd, data: bus.ld_rsp_data};
    end
  end

  // Hazard detection; x0 can never be pending so it never stalls
  assign bus.stall        = pending_q[bus.raddr1] | pending_q[bus.raddr2];
  assign bus.pending      = pending_q;
  assign bus.ld_rsp_ready = rsp_ready;
  assign bus.reg_wr       = reg_wr_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;

endmodule
